// File: rtl/threeadd_pkg.sv
// Shared types and helpers for the bit-serial three-operand adder.
// FSM state enum, carry width and counter-width helper.
package threeadd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned CARRY_W = 2;

    // A one-bit counter is still needed when the operand width is 2 or less.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/threeadd_bitcell.sv
// Three-input full-adder column cell with a 2-bit carry.
// Sums three bits plus carry (0..5) into a sum bit and the next carry (0..2).
module threeadd_bitcell
    import threeadd_pkg::*;
(
    input  logic               a,
    input  logic               b,
    input  logic               c,
    input  logic [CARRY_W-1:0] carry_in,
    output logic               s,
    output logic [CARRY_W-1:0] carry_out
);

    logic [2:0] total;

    assign total     = {2'b00, a} + {2'b00, b} + {2'b00, c} + {1'b0, carry_in};
    assign s         = total[0];
    assign carry_out = total[2:1];

endmodule

// File: rtl/threeadd_seq.sv
// Bit-serial sequencer for a three-operand adder, one bit column per cycle.
// Optional overflow flag register is built when THREEADD_OVF_EN is defined.
module threeadd_seq
    import threeadd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   c_q;
    logic [WIDTH-1:0]   res_q;
    logic [CARRY_W-1:0] carry_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH+1:0]   sum_q;

    logic               cell_s;
    logic [CARRY_W-1:0] cell_carry;
    logic               last_col;

    threeadd_bitcell u_bitcell (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .c         (c_q[0]),
        .carry_in  (carry_q),
        .s         (cell_s),
        .carry_out (cell_carry)
    );

    assign last_col = (state_q == StRun) && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= c;
                        carry_q <= '0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    c_q     <= c_q >> 1;
                    res_q   <= {cell_s, res_q[WIDTH-1:1]};
                    carry_q <= cell_carry;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_col) begin
                        // Final column: its sum bit lands at WIDTH-1, carry fills the top two bits.
                        sum_q   <= {cell_carry, cell_s, res_q[WIDTH-1:1]};
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign sum       = sum_q;

`ifdef THREEADD_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (last_col) begin
            ovf_q <= (cell_carry != '0);
        end else if ((state_q == StDone) && out_ready) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_threeadd_seq.sv
// Self-checking bench for threeadd_seq: directed cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_threeadd_seq;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] sum;
    logic             busy;
    logic             ovf;

    int     tests  = 0;
    int     failed = 0;
    longint cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    threeadd_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic longint ref_sum(input longint x, input longint y, input longint z);
        return x + y + z;
    endfunction

    function automatic longint ref_ovf(input longint s);
`ifdef THREEADD_OVF_EN
        return (s >= (longint'(1) << WIDTH)) ? 1 : 0;
`else
        return (s >= 0) ? 0 : 0;
`endif
    endfunction

    // Enter #1 after a rising edge with the DUT idle; leave the same way after release.
    task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input logic [WIDTH-1:0] oc, input int stall, input bit pulse_run,
                         output longint acc_cyc);
        longint exp_s;
        exp_s = ref_sum(oa, ob, oc);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a = oa;
        b = ob;
        c = oc;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = WIDTH'($urandom);
        for (int k = 1; k <= WIDTH; k++) begin
            if (k == 2 && pulse_run) begin
                in_valid = 1'b1;
                a = 8'h55;
                b = 8'h55;
                c = 8'h55;
                check("in_ready_run", in_ready, 0);
            end
            if (k == 3 && pulse_run) begin
                in_valid = 1'b0;
                check("in_ready_run_after_pulse", in_ready, 0);
            end
            if (k == WIDTH - 1) begin
                check("out_valid_early", out_valid, 0);
                check("busy_run", busy, 1);
            end
            @(posedge clk);
            #1;
        end
        check("out_valid_latency", out_valid, 1);
        check("sum", sum, exp_s);
        check("ovf", ovf, ref_ovf(exp_s));
        check("busy_done", busy, 1);
        check("in_ready_done", in_ready, 0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check("sum_hold", sum, exp_s);
            check("out_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_release", out_valid, 0);
        check("in_ready_release", in_ready, 1);
        check("busy_release", busy, 0);
        check("ovf_release", ovf, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint t0;
        longint t1;
        longint dummy;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c         = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;

        do_op(8'd1, 8'd2, 8'd3, 0, 1'b0, dummy);
        do_op(8'hFF, 8'hFF, 8'hFF, 0, 1'b0, dummy);
        check("max_sum_const", sum, 765);

        // Back-to-back with immediate release: initiation interval WIDTH+2.
        do_op(8'd0, 8'd0, 8'd0, 0, 1'b0, t0);
        do_op(8'd0, 8'd0, 8'd0, 0, 1'b0, t1);
        check("init_interval", t1 - t0, WIDTH + 2);

        do_op(8'd200, 8'd100, 8'd0, 5, 1'b0, dummy);
        do_op(8'd7, 8'd9, 8'd11, 0, 1'b1, dummy);

        // Reset sampled on the 4th RUN edge discards the operation.
        in_valid = 1'b1;
        a = 8'd99;
        b = 8'd98;
        c = 8'd97;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_sum", sum, 0);
        check("midrun_rst_ovf", ovf, 0);
        do_op(8'd10, 8'd20, 8'd30, 0, 1'b0, dummy);

        for (int i = 0; i < 20; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), dummy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
